// File: rtl/dw01_sub_seq_8_2.sv
// dw01_sub_seq_8_2: digit-serial subtractor, DIFF = A - B - BI computed DIGIT bits per cycle
module dw01_sub_seq_8_2 #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_bi,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_bo,
  output logic             o_ovf
);
  localparam int N = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_diff;
  logic [CW-1:0] r_cnt;
  logic r_borrow, r_am, r_bm, r_bo, r_ovf;
  logic [DIGIT:0] w_sub;
  logic w_last, w_accept;
  assign w_sub = {1'b0, r_a[DIGIT-1:0]} - {1'b0, r_b[DIGIT-1:0]} - {{DIGIT{1'b0}}, r_borrow};
  assign w_last = r_cnt == CW'(N - 1);
  assign w_accept = r_state == IDLE && i_in_valid;
  assign o_in_ready = r_state == IDLE;
  assign o_out_valid = r_state == DONE;
  assign o_diff = r_diff;
  assign o_bo = r_bo;
  assign o_ovf = r_ovf;
  always_comb begin
    w_next = r_state;
    w_next = w_accept ? RUN :
             (r_state == RUN && w_last) ? DONE :
             (r_state == DONE && i_out_ready) ? IDLE : r_state;
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_state <= IDLE;
    else r_state <= w_next;
  // Operand MSBs are kept aside because the shift registers consume them before overflow is known.
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_a <= '0;
      r_b <= '0;
      r_borrow <= 1'b0;
      r_cnt <= '0;
      r_am <= 1'b0;
      r_bm <= 1'b0;
      r_diff <= '0;
      r_bo <= 1'b0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_a <= i_a;
      r_b <= i_b;
      r_borrow <= i_bi;
      r_cnt <= '0;
      r_am <= i_a[WIDTH-1];
      r_bm <= i_b[WIDTH-1];
    end else if (r_state == RUN) begin
      r_a <= r_a >> DIGIT;
      r_b <= r_b >> DIGIT;
      r_borrow <= w_sub[DIGIT];
      r_cnt <= r_cnt + CW'(1);
      r_diff <= {w_sub[DIGIT-1:0], r_diff[WIDTH-1:DIGIT]};
      if (w_last) begin
        r_bo <= w_sub[DIGIT];
        r_ovf <= (r_am != r_bm) & (w_sub[DIGIT-1] != r_am);
      end
    end
endmodule

// File: tb/tb_dw01_sub_seq_8_2.sv
// tb_dw01_sub_seq_8_2: random and directed checks of the digit-serial subtractor against an arithmetic model
module tb_dw01_sub_seq_8_2;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic bi = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic in_ready, out_valid, bo, ovf;
  logic [7:0] diff;
  int errs = 0;
  int chks = 0;
  int cyc = 0;
  int last_acc = -1;

  dw01_sub_seq_8_2 dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_in_valid(in_valid),
    .o_in_ready(in_ready),
    .i_a(a),
    .i_b(b),
    .i_bi(bi),
    .o_out_valid(out_valid),
    .i_out_ready(out_ready),
    .o_diff(diff),
    .o_bo(bo),
    .o_ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input int got, input int exp);
    chks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned for DIFF/BO, signed range for OVF.
  function automatic void model(input logic [7:0] ma, input logic [7:0] mb, input logic mbi,
                                output logic [7:0] d, output logic mbo, output logic movf);
    int u, s;
    u = int'(ma) - int'(mb) - int'(mbi);
    s = int'($signed(ma)) - int'($signed(mb)) - int'(mbi);
    d = u[7:0];
    mbo = u < 0;
    movf = s < -128 || s > 127;
  endfunction

  // Called #1 after a clock edge with the DUT expected in IDLE.
  task automatic op(input logic [7:0] oa, input logic [7:0] ob, input logic obi,
                    input int stall, input bit hold, input bit chk_period);
    logic [7:0] ed;
    logic ebo, eovf;
    int n;
    model(oa, ob, obi, ed, ebo, eovf);
    a = oa;
    b = ob;
    bi = obi;
    in_valid = 1'b1;
    out_ready = stall == 0;
    check("in_ready_idle", int'(in_ready), 1);
    @(posedge clk);
    #1;
    if (chk_period && last_acc >= 0) check("issue_period", cyc - last_acc, N + 2);
    last_acc = cyc;
    in_valid = hold;
    a = 8'($urandom);
    b = 8'($urandom);
    bi = 1'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", n, N);
    check("diff", int'(diff), int'(ed));
    check("bo", int'(bo), int'(ebo));
    check("ovf", int'(ovf), int'(eovf));
    check("in_ready_done", int'(in_ready), 0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check("stall_valid", int'(out_valid), 1);
      check("stall_hold", int'({diff, bo, ovf, in_ready}), int'({ed, ebo, eovf, 1'b0}));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_hs_valid", int'(out_valid), 0);
    check("post_hs_ready", int'(in_ready), 1);
    check("post_hs_keep", int'({diff, bo, ovf}), int'({ed, ebo, eovf}));
  endtask

  initial begin
    int bad;
    #2;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out", int'({out_valid, diff, bo, ovf}), 0);
    #10;
    rst = 1'b0;
    @(posedge clk);
    #1;
    op(8'h05, 8'h03, 1'b0, 0, 1'b0, 1'b0);
    op(8'h00, 8'h01, 1'b0, 0, 1'b0, 1'b0);
    op(8'hFF, 8'hFF, 1'b1, 0, 1'b0, 1'b0);
    op(8'h80, 8'h01, 1'b0, 0, 1'b0, 1'b0);
    op(8'h7F, 8'hFF, 1'b0, 0, 1'b0, 1'b0);
    op(8'h80, 8'h00, 1'b1, 0, 1'b0, 1'b0);
    op(8'h00, 8'h00, 1'b1, 3, 1'b0, 1'b0);
    last_acc = -1;
    for (int k = 0; k < 5; k++) op(8'($urandom), 8'($urandom), 1'($urandom), 0, 1'b1, 1'b1);
    in_valid = 1'b0;
    for (int k = 0; k < 25; k++)
      op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'b0, 1'b0);
    a = 8'h55;
    b = 8'h22;
    bi = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_out", int'({out_valid, diff, bo, ovf}), 0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) bad++;
    end
    check("abort_no_pulse", bad, 0);
    op(8'h10, 8'h01, 1'b0, 0, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
